// File: rtl/param_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, optional
// output pipeline stage and a post-reset zero-fill sequence.
module param_dp_ram #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              clearing;
  logic              wr_fire;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  assign clearing = (state_q == ST_CLEAR);
  assign wr_fire  = wr_en & ~clearing;
  assign rd_fire  = rd_en & ~clearing;

  // The clear sequence owns the single write port while it runs.
  assign mem_we    = clearing | wr_fire;
  assign mem_waddr = clearing ? clr_cnt_q : wr_addr;
  assign mem_wdata = clearing ? '0 : wr_data;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if ((RDW_MODE != 0) && wr_fire && (wr_addr == rd_addr)) begin
      rd_word = wr_data;
    end
  end

  always_comb begin
    pipe_data_d = pipe_data_q;
    pipe_vld_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    if (OUT_REG != 0) begin
      pipe_vld_d = rd_fire;
      if (rd_fire) pipe_data_d = rd_word;
      rd_valid_d = pipe_vld_q;
      if (pipe_vld_q) rd_data_d = pipe_data_q;
    end else begin
      rd_valid_d = rd_fire;
      if (rd_fire) rd_data_d = rd_word;
    end
  end

  // NOTE: the storage array has no reset; zeroing it is the job of the clear sequence.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      clr_cnt_q   <= '0;
      pipe_data_q <= '0;
      pipe_vld_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pipe_data_q <= pipe_data_d;
      pipe_vld_q  <= pipe_vld_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = clearing;

endmodule

// File: tb/tb_param_dp_ram.sv
// Scoreboard bench for param_dp_ram: a read-old/latency-1 instance, a
// write-first/latency-2 instance and a no-clear instance share one stimulus.
module tb_param_dp_ram;

  typedef struct packed {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en;
  logic [5:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic       rd_valid0, rd_valid1, rd_valid2;
  logic       busy0, busy1, busy2;

  always #5 clock = ~clock;

  param_dp_ram #(.RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

  param_dp_ram #(.RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

  param_dp_ram #(.RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last0, last1;
  logic [7:0] m_mem [64];
  logic       m_busy;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_rd(input int id, input logic v, input logic [7:0] d);
    exp_t e;
    logic exp_v;
    e     = '0;
    exp_v = 1'b0;
    if (id == 0) begin
      if (q0.size() > 0 && q0[0].due == edge_n) begin exp_v = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && q1[0].due == edge_n) begin exp_v = 1'b1; e = q1.pop_front(); end
    end
    check($sformatf("rd_valid%0d", id), {31'd0, v}, {31'd0, exp_v});
    if (exp_v) begin
      check($sformatf("rd_data%0d", id), {24'd0, d}, {24'd0, e.data});
      if (id == 0) last0 = e.data; else last1 = e.data;
    end else begin
      check($sformatf("rd_hold%0d", id), {24'd0, d}, {24'd0, (id == 0) ? last0 : last1});
    end
  endtask

  // One clock: book expectations from the inputs, advance the model, check at negedge.
  task automatic step();
    if (rd_en && !m_busy) begin
      q0.push_back('{data: m_mem[rd_addr], due: edge_n + 1});
      q1.push_back('{data: (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr],
                     due: edge_n + 2});
    end
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == 64) begin
        m_busy = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
      end
    end else if (wr_en) begin
      m_mem[wr_addr] = wr_data;
    end
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    check("busy0", {31'd0, busy0}, {31'd0, m_busy});
    check("busy1", {31'd0, busy1}, {31'd0, m_busy});
    check("busy2", {31'd0, busy2}, 32'd0);
    check_rd(0, rd_valid0, rd_data0);
    check_rd(1, rd_valid1, rd_data1);
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_rd_data0", {24'd0, rd_data0}, 32'd0);
    check("rst_rd_valid0", {31'd0, rd_valid0}, 32'd0);
    check("rst_rd_data1", {24'd0, rd_data1}, 32'd0);
    check("rst_rd_valid1", {31'd0, rd_valid1}, 32'd0);
    check("rst_rd_data2", {24'd0, rd_data2}, 32'd0);
    check("rst_rd_valid2", {31'd0, rd_valid2}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    q0.delete();
    q1.delete();
    last0  = 8'h00;
    last1  = 8'h00;
    m_busy = 1'b1;
    m_cnt  = 0;
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'hxx;
    @(negedge clock);
    do_reset();

    // Requests at clear cycle 10 are dropped; reset again at clear cycle 20.
    idle(10);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hAA;
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    idle(9);
    do_reset();
    idle(64);

    rd(6'd63);
    rd(6'd5);
    idle(3);

    wr(6'd0, 8'h01);
    wr(6'd1, 8'h02);
    wr(6'd2, 8'h03);
    rd(6'd0);
    rd(6'd1);
    rd(6'd2);
    idle(3);

    // Same-address write and read on one edge.
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'h04;
    rd_en = 1'b1; rd_addr = 6'd1;
    step();
    rd(6'd1);
    idle(3);

    wr(6'd7, 8'h5A);
    rd(6'd7);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 6'($urandom_range(0, 7));
      step();
    end
    idle(3);

    // Reset while the two-stage read is still in flight.
    rd_en = 1'b1; rd_addr = 6'd7;
    step();
    rd_en = 1'b0;
    do_reset();
    idle(66);
    rd(6'd7);
    idle(3);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
